uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter SB_TICK, default 16, number of s_tick periods in the stop field; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  single-cycle sample enable from the baud generator, at 16x the bit rate.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-008 dout  output  8  received data; bits [DBIT-1:0] valid, upper bits 0.
REQ-009 frame_err  output  1  stop bit sampled low on the last completed frame.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer, reset value 1; all logic below uses the synchronized rx_s.
REQ-011 States: IDLE, START, DATA, STOP, plus PARITY when the macro is defined; 4-bit tick counter s; 3-bit bit counter n; 8-bit shift register b.
REQ-012 Counters SHALL advance only in cycles with s_tick=1; cycles without s_tick SHALL hold all state.
REQ-013 IDLE: when rx_s=0, go to START and clear s; s_tick is not required.
REQ-014 START: on s_tick with s=7, sample rx_s. If 0, go to DATA and clear s and n. If 1, treat as a glitch and return to IDLE with no output. Otherwise s increments.
REQ-015 DATA: on s_tick with s=15, shift rx_s into b[7] (right shift, LSB first) and clear s. If n=DBIT-1, go to STOP (or PARITY); otherwise n increments.
REQ-016 STOP: on s_tick with s=SB_TICK-1, do all of the following in the same cycle: pulse rx_done_tick, load dout with b right-aligned to DBIT (upper bits 0), set frame_err = ~rx_s, return to IDLE.
REQ-017 dout and frame_err SHALL hold their values until the next rx_done_tick.
REQ-018 rx_done_tick SHALL be high for exactly one clk per frame, never for aborted frames.
REQ-019 A new falling edge seen in IDLE in the cycle after STOP exit SHALL start a new frame; back-to-back frames SHALL be received without loss.
REQ-020 A low line that stays low (break) SHALL give one frame with data 0 and frame_err=1. The receiver then waits in IDLE and only starts a new frame after rx_s has gone high and then low again.

Reset
REQ-021 Reset SHALL force state IDLE, s=0, n=0, b=0, dout=0, frame_err=0, rx_done_tick=0, synchronizer flops=1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame with no rx_done_tick. After release the block waits for a new start edge.

Configuration
REQ-023 Macro UART_RX_PARITY_EN: when defined, add output parity_err (1 bit, reset 0) and state PARITY between DATA and STOP.
REQ-024 PARITY: on s_tick with s=15, sample the parity bit, clear s, go to STOP. parity_err is set to (XOR of data bits XOR sampled bit) and is updated with dout at rx_done_tick; the check is even parity.
REQ-025 Without the macro: no parity_err port, no PARITY state; DATA goes directly to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16, MID_SAMPLE=7 and the default DBIT/SB_TICK constants.
REQ-027 The synchronizer SHALL be sub-module uart_sync2 (2-flop, async active-high reset to 1).
REQ-028 Everything else SHALL be a single FSM with registered outputs; no combinational path from rx to any output.

Verification (s_tick every 4 clk, 16 ticks/bit, DBIT=8, SB_TICK=16)
REQ-029 Send 0xA5 with a valid stop bit -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-030 Drive rx low for 4 s_ticks, then high -> no rx_done_tick; state returns to IDLE.
REQ-031 Send 0x3C with the stop bit driven low -> dout=0x3C, frame_err=1.
REQ-032 Send 0x00 then 0xFF back-to-back with zero idle gap -> two pulses, dout 0x00 then 0xFF.
REQ-033 Assert reset during data bit 4 of 0x5A, release, send 0x81 -> only one rx_done_tick, dout=0x81.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// UART_RX_PARITY_EN adds a PARITY state between DATA and STOP.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int MID_SAMPLE      = 7;
    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver with registered outputs.
// Define UART_RX_PARITY_EN to add an even-parity check and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge (after the line has been high)
// START  | counting to the middle of the start bit, rejecting glitches
// DATA   | sampling DBIT data bits LSB first, one per 16 ticks
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting SB_TICK ticks, then publishing the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    // Four bits covers one stop bit; longer stop fields need a wider tick counter.
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    logic           rx_s;
    state_t         state_q, state_d;
    logic [S_W-1:0] s_q, s_d;
    logic [2:0]     n_q, n_d;
    logic [7:0]     b_q, b_d;
    logic [7:0]     dout_q, dout_d;
    logic           ferr_q, ferr_d;
    logic           done_q, done_d;
    logic           armed_q, armed_d;
    logic [7:0]     b_aligned;
`ifdef UART_RX_PARITY_EN
    logic           par_q, par_d;
    logic           perr_q, perr_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign b_aligned = b_q >> (8 - DBIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        // armed blocks a held-low line (break) from retriggering until it returns high
        armed_d = armed_q | rx_s;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s && armed_q) begin
                    state_d = ST_START;
                    s_d     = '0;
                    armed_d = 1'b0;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == S_W'(MID_SAMPLE)) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVERSAMPLE - 1)) begin
                        b_d = {rx_s, b_q[7:1]};
                        s_d = '0;
                        if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == S_W'(OVERSAMPLE - 1)) begin
                        par_d   = rx_s;
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == S_W'(SB_TICK - 1)) begin
                        done_d  = 1'b1;
                        dout_d  = b_aligned;
                        ferr_d  = ~rx_s;
                        armed_d = rx_s;
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^b_aligned) ^ par_q;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_done_tick = done_q;
    assign dout         = dout_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed, scoreboard-based bench for uart_rx (s_tick every 4 clk, 16 ticks per bit).
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pulse  = 0;

    always #5 clk = ~clk;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        exp_t e;
        e.data = d;
        e.ferr = ~stop_bit;
        e.perr = (^d) ^ par_bit;
        sb.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_bit);
`endif
        send_bit(stop_bit);
    endtask

    // s_tick generator: one cycle in four
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            s_tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    // output monitor: every pulse must match the oldest expected frame
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_done_tick) begin
                n_pulse++;
                check("pulse_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("dout", dout, e.data);
                    check("frame_err", frame_err, e.ferr);
`ifdef UART_RX_PARITY_EN
                    check("parity_err", parity_err, e.perr);
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(5);
        check("reset_dout", dout, 8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_done", rx_done_tick, 1'b0);
`ifdef UART_RX_PARITY_EN
        check("reset_parity_err", parity_err, 1'b0);
`endif
        reset = 1'b0;
        wait_clks(20);

        // clean frame
        send_frame(8'hA5, 1'b1, ^8'hA5);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("a5_consumed", sb.size(), 0);
        check("a5_pulses", n_pulse, 1);

        // start-bit glitch of 4 ticks
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_pulses", n_pulse, 1);
        check("glitch_idle", (dut.state_q === ST_IDLE), 1);
        check("glitch_hold_dout", dout, 8'hA5);
        check("glitch_hold_ferr", frame_err, 1'b0);

        // framing error
        send_frame(8'h3C, 1'b0, ^8'h3C);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("3c_consumed", sb.size(), 0);
        check("3c_pulses", n_pulse, 2);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("b2b_consumed", sb.size(), 0);
        check("b2b_pulses", n_pulse, 4);

        // break: one zero frame with frame_err, then no retrigger while low
        sb.push_back('{data: 8'h00, ferr: 1'b1, perr: 1'b0});
        rx = 1'b0;
        wait_clks(14 * BIT_CLKS);
        check("break_pulses", n_pulse, 5);
        check("break_consumed", sb.size(), 0);
        check("break_idle", (dut.state_q === ST_IDLE), 1);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        send_frame(8'h55, 1'b1, ^8'h55);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("after_break_consumed", sb.size(), 0);
        check("after_break_pulses", n_pulse, 6);

        // reset during data bit 4 of 0x5A, then 0x81
        p = n_pulse;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        wait_clks(BIT_CLKS / 2);
        reset = 1'b1;
        rx    = 1'b1;
        wait_clks(10);
        check("midreset_dout", dout, 8'h00);
        check("midreset_ferr", frame_err, 1'b0);
        reset = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("midreset_no_pulse", n_pulse, p);
        send_frame(8'h81, 1'b1, ^8'h81);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("81_consumed", sb.size(), 0);
        check("81_pulses", n_pulse, p + 1);
        check("81_hold_dout", dout, 8'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("parity_consumed", sb.size(), 0);
        check("parity_hold", parity_err, 1'b0);
`endif

        wait_clks(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
